inst_fetch_queue: RTL and testbench

Parametrised instruction buffer between instruction fetch and decoder; successor to the fixed 8-entry queue.
- Full DEPTH capacity: count-based, no sacrificed slot.
- Configurable almost-full throttle for fetch.
- Per-entry branch-prediction bit carried through to the decoder.
- Occupancy output and sticky overflow flag for debug and verification.
- Flushed by reorder buffer, decoder or branch predictor.

---
 rtl/inst_fetch_queue_pkg.sv | 11 +
 rtl/inst_fetch_queue_iq_storage.sv | 26 ++
 rtl/inst_fetch_queue.sv | 103 ++++++++++
 tb/tb_inst_fetch_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and constants for the fetch/decode boundary.
// Fetch and the instruction queue both take their depth from IQ_DEPTH.
package inst_fetch_queue_pkg;

    localparam int ID_WIDTH   = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int IQ_DEPTH   = 8;

    localparam logic [ID_WIDTH-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_queue_iq_storage.sv
// Instruction queue entry array.
// One synchronous write port and one asynchronous read port.
module iq_storage #(
    parameter int DEPTH = 8,
    parameter int W     = 65,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Count-based instruction buffer between fetch and decode.
// Holds DEPTH entries of {inst, pc, predicted-taken}.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH        = IQ_DEPTH,
    parameter int INST_W       = ID_WIDTH,
    parameter int ADDR_W       = ADDR_WIDTH,
    parameter int AFULL_MARGIN = 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_en_in,
    input  logic [INST_W-1:0] if_inst_in,
    input  logic [ADDR_W-1:0] if_pc_in,
    input  logic              if_pred_taken_in,
    output logic              iq_if_rdy_out,
    input  logic              rs_rdy_in,
    input  logic              rob_rdy_in,
    input  logic              rob_flush_in,
    input  logic              decoder_flush_in,
    input  logic              bp_flush_in,
    output logic              dec_en_out,
    output logic [INST_W-1:0] dec_inst_out,
    output logic [ADDR_W-1:0] dec_pc_out,
    output logic              dec_pred_taken_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              overflow_err_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = INST_W + ADDR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] wr_ent;
    logic [ENT_W-1:0] rd_ent;
    logic             flush;
    logic             full;
    logic             deq;
    logic             enq_ok;
    logic             wr_en;

    assign flush  = rob_flush_in | decoder_flush_in | bp_flush_in;
    assign full   = (count == CNT_W'(DEPTH));
    assign deq    = rs_rdy_in & rob_rdy_in & (count != '0);
    // A dequeue in the same edge frees the slot a full-queue enqueue needs.
    assign enq_ok = if_en_in & (~full | deq);
    assign wr_en  = rdy_in & ~rst_in & ~flush & enq_ok;
    assign wr_ent = {if_inst_in, if_pc_in, if_pred_taken_in};

    iq_storage #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_storage (
        .clk_in (clk_in),
        .we     (wr_en),
        .waddr  (tail),
        .wdata  (wr_ent),
        .raddr  (head),
        .rdata  (rd_ent)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            dec_en_out         <= 1'b0;
            dec_inst_out       <= INST_W'(NOP);
            dec_pc_out         <= '0;
            dec_pred_taken_out <= 1'b0;
            overflow_err_out   <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                dec_en_out <= 1'b0;
            end else begin
                if (enq_ok) begin
                    tail <= tail + PTR_W'(1);
                end
                if (if_en_in && !enq_ok) begin
                    overflow_err_out <= 1'b1;
                end
                if (deq) begin
                    {dec_inst_out, dec_pc_out, dec_pred_taken_out} <= rd_ent;
                    head <= head + PTR_W'(1);
                end
                dec_en_out <= deq;
                count <= count + CNT_W'(enq_ok) - CNT_W'(deq);
            end
        end
    end

    assign iq_if_rdy_out = (count <= CNT_W'(DEPTH - AFULL_MARGIN));
    assign count_out     = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed and table-driven bench for inst_fetch_queue.
// Runs a DEPTH=8/AFULL=2 and a DEPTH=4/AFULL=1 instance on shared stimulus.
module tb_inst_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_en_in;
    logic [31:0] if_inst_in;
    logic [31:0] if_pc_in;
    logic        if_pred_taken_in;
    logic        rs_rdy_in;
    logic        rob_rdy_in;
    logic        rob_flush_in;
    logic        decoder_flush_in;
    logic        bp_flush_in;

    logic        ifrdy8, en8, pred8, ovf8;
    logic [31:0] inst8, pc8;
    logic [3:0]  cnt8;
    logic        ifrdy4, en4, pred4, ovf4;
    logic [31:0] inst4, pc4;
    logic [2:0]  cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    inst_fetch_queue #(.DEPTH(8), .AFULL_MARGIN(2)) dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_en_in(if_en_in), .if_inst_in(if_inst_in), .if_pc_in(if_pc_in),
        .if_pred_taken_in(if_pred_taken_in), .iq_if_rdy_out(ifrdy8),
        .rs_rdy_in(rs_rdy_in), .rob_rdy_in(rob_rdy_in),
        .rob_flush_in(rob_flush_in), .decoder_flush_in(decoder_flush_in),
        .bp_flush_in(bp_flush_in), .dec_en_out(en8), .dec_inst_out(inst8),
        .dec_pc_out(pc8), .dec_pred_taken_out(pred8), .count_out(cnt8),
        .overflow_err_out(ovf8)
    );

    inst_fetch_queue #(.DEPTH(4), .AFULL_MARGIN(1)) dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_en_in(if_en_in), .if_inst_in(if_inst_in), .if_pc_in(if_pc_in),
        .if_pred_taken_in(if_pred_taken_in), .iq_if_rdy_out(ifrdy4),
        .rs_rdy_in(rs_rdy_in), .rob_rdy_in(rob_rdy_in),
        .rob_flush_in(rob_flush_in), .decoder_flush_in(decoder_flush_in),
        .bp_flush_in(bp_flush_in), .dec_en_out(en4), .dec_inst_out(inst4),
        .dec_pc_out(pc4), .dec_pred_taken_out(pred4), .count_out(cnt4),
        .overflow_err_out(ovf4)
    );

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        e_en;
        logic [31:0] e_pc;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vt[5];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc * 3 + 32'h1000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] pc);
        if_en_in         = en;
        if_pc_in         = pc;
        if_inst_in       = inst_of(pc);
        if_pred_taken_in = pc[2];
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_issue8(input string name, input logic [31:0] pc);
        chk({name, "_en"}, 32'(en8), 32'd1);
        chk({name, "_pc"}, pc8, pc);
        chk({name, "_inst"}, inst8, inst_of(pc));
        chk({name, "_pred"}, 32'(pred8), 32'(pc[2]));
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        drive(1'b0, 32'h0);
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        rdy_in = 1'b1;
        rs_rdy_in = 1'b1;
        rob_rdy_in = 1'b1;
        rob_flush_in = 1'b0;
        decoder_flush_in = 1'b0;
        bp_flush_in = 1'b0;
        do_reset();

        chk("rst_cnt", 32'(cnt8), 32'd0);
        chk("rst_en", 32'(en8), 32'd0);
        chk("rst_inst", inst8, 32'h13);
        chk("rst_pc", pc8, 32'h0);
        chk("rst_pred", 32'(pred8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_ifrdy", 32'(ifrdy8), 32'd1);
        chk("rst_ifrdy4", 32'(ifrdy4), 32'd1);

        // basic stream: no bypass, back-to-back issue
        vt[0] = '{1'b1, 32'h0, 1'b0, 32'h0, 4'd1};
        vt[1] = '{1'b1, 32'h4, 1'b1, 32'h0, 4'd1};
        vt[2] = '{1'b1, 32'h8, 1'b1, 32'h4, 4'd1};
        vt[3] = '{1'b0, 32'h0, 1'b1, 32'h8, 4'd0};
        vt[4] = '{1'b0, 32'h0, 1'b0, 32'h8, 4'd0};
        for (int i = 0; i < 5; i++) begin
            drive(vt[i].en, vt[i].pc);
            step();
            chk($sformatf("vec%0d_en", i), 32'(en8), 32'(vt[i].e_en));
            chk($sformatf("vec%0d_pc", i), pc8, vt[i].e_pc);
            chk($sformatf("vec%0d_cnt", i), 32'(cnt8), 32'(vt[i].e_cnt));
        end

        // fill to 8, watching the almost-full throttle
        do_reset();
        rs_rdy_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * (i - 1)));
            step();
            chk($sformatf("fill%0d_cnt", i), 32'(cnt8), 32'(i));
            chk($sformatf("fill%0d_ifrdy", i), 32'(ifrdy8), 32'(i <= 6));
            chk($sformatf("fill%0d_en", i), 32'(en8), 32'd0);
        end
        // full: simultaneous enqueue and dequeue
        rs_rdy_in = 1'b1;
        drive(1'b1, 32'h200);
        step();
        chk("full_sim_cnt", 32'(cnt8), 32'd8);
        chk("full_sim_ovf", 32'(ovf8), 32'd0);
        chk_issue8("full_sim", 32'h10);
        // full: enqueue without dequeue is dropped
        rs_rdy_in = 1'b0;
        drive(1'b1, 32'h300);
        step();
        chk("ovf_cnt", 32'(cnt8), 32'd8);
        chk("ovf_flag", 32'(ovf8), 32'd1);
        chk("ovf_en", 32'(en8), 32'd0);
        rs_rdy_in = 1'b1;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_issue8($sformatf("drain%0d", i),
                       i == 7 ? 32'h200 : 32'h14 + 32'(4 * i));
            chk($sformatf("drain%0d_cnt", i), 32'(cnt8), 32'(7 - i));
        end
        step();
        chk("drain_end_en", 32'(en8), 32'd0);
        chk("ovf_sticky", 32'(ovf8), 32'd1);

        // flush with concurrent enqueue and issue readiness
        do_reset();
        rs_rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h80 + 32'(4 * i));
            step();
        end
        chk("pre_flush_cnt", 32'(cnt8), 32'd5);
        rs_rdy_in = 1'b1;
        bp_flush_in = 1'b1;
        drive(1'b1, 32'h500);
        step();
        bp_flush_in = 1'b0;
        chk("flush_cnt", 32'(cnt8), 32'd0);
        chk("flush_en", 32'(en8), 32'd0);
        drive(1'b1, 32'h100);
        step();
        chk("post_flush_cnt", 32'(cnt8), 32'd1);
        chk("post_flush_en", 32'(en8), 32'd0);
        drive(1'b0, 32'h0);
        step();
        chk_issue8("post_flush", 32'h100);
        chk("post_flush_cnt2", 32'(cnt8), 32'd0);

        // rdy_in low freezes everything
        do_reset();
        drive(1'b1, 32'h40);
        step();
        drive(1'b1, 32'h44);
        step();
        chk_issue8("stall_pre", 32'h40);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i != 1, 32'h48);
            step();
            chk_issue8($sformatf("stall%0d", i), 32'h40);
            chk($sformatf("stall%0d_cnt", i), 32'(cnt8), 32'd1);
        end
        rdy_in = 1'b1;
        drive(1'b1, 32'h48);
        step();
        chk_issue8("resume0", 32'h44);
        drive(1'b0, 32'h0);
        step();
        chk_issue8("resume1", 32'h48);
        step();
        chk("resume_end_en", 32'(en8), 32'd0);
        chk("resume_end_cnt", 32'(cnt8), 32'd0);

        // DEPTH=4 random scoreboard run with pointer wrap
        do_reset();
        begin
            logic [31:0] q[$];
            logic [31:0] exp_pc;
            int          cnt;
            logic        ovf;
            logic        en;
            logic        deq;
            logic        ok;
            cnt = 0;
            ovf = 1'b0;
            exp_pc = 32'h0;
            for (int i = 0; i < 30; i++) begin
                en = ($urandom_range(0, 99) < 65);
                rs_rdy_in = ($urandom_range(0, 99) < 55);
                drive(en, 32'h1000 + 32'(4 * i));
                deq = rs_rdy_in && cnt != 0;
                ok = en && (cnt < 4 || deq);
                if (en && !ok) ovf = 1'b1;
                if (deq) exp_pc = q.pop_front();
                if (ok) q.push_back(if_pc_in);
                cnt = cnt + int'(ok) - int'(deq);
                step();
                chk($sformatf("rnd%0d_cnt", i), 32'(cnt4), 32'(cnt));
                chk($sformatf("rnd%0d_en", i), 32'(en4), 32'(deq));
                chk($sformatf("rnd%0d_ifrdy", i), 32'(ifrdy4), 32'(cnt <= 3));
                chk($sformatf("rnd%0d_ovf", i), 32'(ovf4), 32'(ovf));
                if (deq) begin
                    chk($sformatf("rnd%0d_pc", i), pc4, exp_pc);
                    chk($sformatf("rnd%0d_inst", i), inst4, inst_of(exp_pc));
                    chk($sformatf("rnd%0d_pred", i), 32'(pred4),
                        32'(exp_pc[2]));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
